// File: rtl/mem_stage_async_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_async_pkg : bus layouts, FSM encodings and mem_op indices for MEM
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_stage_async_pkg;

  // mem_op is one-hot; each index names a load flavour
  localparam int OP_B     = 0;
  localparam int OP_BU    = 1;
  localparam int OP_H     = 2;
  localparam int OP_HU    = 3;
  localparam int OP_W     = 4;
  localparam int OP_WL    = 5;
  localparam int OP_WR    = 6;
  localparam int MEM_OP_W = 7;

  typedef logic [1:0] ms_state_t;
  localparam ms_state_t MS_IDLE = 2'd0;
  localparam ms_state_t MS_WAIT = 2'd1;
  localparam ms_state_t MS_DONE = 2'd2;

  typedef struct packed {
    logic                excp_valid;
    logic [4:0]          execode;
    logic                es_req;
    logic [MEM_OP_W-1:0] mem_op;
    logic                res_from_mem;
    logic                gr_we;
    logic [4:0]          dest;
    logic [31:0]         rt_value;
    logic [31:0]         alu_result;
    logic [31:0]         pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        excp_valid;
    logic [4:0]  execode;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
  } ms_fw_t;

  localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
  localparam int MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);
  localparam int FW_BUS_WD       = $bits(ms_fw_t);

endpackage

`default_nettype wire

// File: rtl/mem_stage_async_if.sv
// ----------------------------------------------------------------------------
// mem_stage_async_if : EXE/WB handshakes, forwarding and data-memory response
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mem_stage_async_if #(
  parameter int DATA_W = 32
);
  import mem_stage_async_pkg::*;

  logic              es_to_ms_valid;
  es_to_ms_t         es_to_ms_bus;
  logic              ms_allowin;
  logic              ws_allowin;
  logic              ms_to_ws_valid;
  ms_to_ws_t         ms_to_ws_bus;
  ms_fw_t            ms_to_ds_fw_bus;
  logic              ms_fw_pending;
  logic              data_sram_data_ok;
  logic [DATA_W-1:0] data_sram_rdata;
  logic              flush;

  // master: the surrounding pipeline and memory; slave: the MEM stage
  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata, flush,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
           ms_to_ds_fw_bus, ms_fw_pending
  );

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata, flush,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
           ms_to_ds_fw_bus, ms_fw_pending
  );

endinterface

`default_nettype wire

// File: rtl/mem_stage_async_ld_align.sv
// ----------------------------------------------------------------------------
// ld_align : picks the addressed 32-bit word and applies b/bu/h/hu/w/wl/wr
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ld_align
  import mem_stage_async_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  wire [DATA_W-1:0]   rdata,
  input  wire [OFF_W-1:0]    off,
  input  wire [MEM_OP_W-1:0] mem_op,
  input  wire [31:0]         rt_value,
  output logic [31:0]        mem_result
);

  logic [31:0] word;
  logic [1:0]  bo;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign bo = off[1:0];

  generate
    if (DATA_W == 32) begin : g_word32
      assign word = rdata[31:0];
    end else begin : g_word_sel
      logic [OFF_W-3:0] wsel;
      assign wsel = off[OFF_W-1:2];
      assign word = rdata[{wsel, 5'b00000} +: 32];
    end
  endgenerate

  always_comb begin
    byte_v     = word[{bo, 3'b000} +: 8];
    half_v     = word[{bo[1], 4'b0000} +: 16];
    mem_result = word;
    if (mem_op[OP_B])       mem_result = {{24{byte_v[7]}}, byte_v};
    else if (mem_op[OP_BU]) mem_result = {24'b0, byte_v};
    else if (mem_op[OP_H])  mem_result = {{16{half_v[15]}}, half_v};
    else if (mem_op[OP_HU]) mem_result = {16'b0, half_v};
    else if (mem_op[OP_WL]) begin
      // little-endian lwl: memory bytes fill the register from the top down
      case (bo)
        2'd0:    mem_result = {word[7:0],  rt_value[23:0]};
        2'd1:    mem_result = {word[15:0], rt_value[15:0]};
        2'd2:    mem_result = {word[23:0], rt_value[7:0]};
        default: mem_result = word;
      endcase
    end else if (mem_op[OP_WR]) begin
      case (bo)
        2'd0:    mem_result = word;
        2'd1:    mem_result = {rt_value[31:24], word[31:8]};
        2'd2:    mem_result = {rt_value[31:16], word[31:16]};
        default: mem_result = {rt_value[31:8],  word[31:24]};
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_async.sv
// ----------------------------------------------------------------------------
// mem_stage_async : MEM stage waiting on split-transaction load data, with
// response buffering for WB stalls and draining of cancelled requests. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_stage_async
  import mem_stage_async_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input wire          clk,
  input wire          resetn,
  mem_stage_async_if.slave io
);

  localparam int LANE_BITS = $clog2(DATA_W / 8);
  localparam int CNT_W     = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, CNT_W'(MAX_OUTST)};

  ms_state_t         state;
  ms_state_t         state_nxt;
  es_to_ms_t         ms_bus;
  logic [DATA_W-1:0] rdata_buf;
  logic              buf_vld;
  logic [CNT_W-1:0]  discard_cnt;
  logic [CNT_W:0]    cnt_sum;
  logic              ms_valid;
  logic              ok_hit;
  logic              ready_go;
  logic              accept;
  logic [DATA_W-1:0] ld_src;
  logic [31:0]       mem_result;
  logic [31:0]       final_result;

  assign ms_valid = (state != MS_IDLE);
  // a beat belongs to this instruction only once every cancelled request has drained
  assign ok_hit   = io.data_sram_data_ok && (discard_cnt == '0);
  assign accept   = io.es_to_ms_valid && io.ms_allowin && !io.flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= MS_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (io.flush)                          state_nxt = MS_IDLE;
    else if (accept)                       state_nxt = io.es_to_ms_bus.es_req ? MS_WAIT : MS_DONE;
    else if (ready_go && io.ws_allowin)    state_nxt = MS_IDLE;
    else if (state == MS_WAIT && ok_hit)   state_nxt = MS_DONE;
  end

  always_comb begin
    ready_go          = (state == MS_DONE) || (state == MS_WAIT && ok_hit);
    io.ms_allowin     = !ms_valid || (ready_go && io.ws_allowin);
    io.ms_to_ws_valid = ms_valid && ready_go;
    io.ms_fw_pending  = ms_valid && ms_bus.res_from_mem && !ready_go;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_bus    <= '0;
      rdata_buf <= '0;
      buf_vld   <= 1'b0;
    end else begin
      if (accept) ms_bus <= io.es_to_ms_bus;
      if (state == MS_WAIT && ok_hit) rdata_buf <= io.data_sram_rdata;
      if (io.flush || accept)              buf_vld <= 1'b0;
      else if (state == MS_WAIT && ok_hit) buf_vld <= 1'b1;
    end
  end

  // requests killed by a flush still answer later; count them so their beats are dropped
  always_comb begin
    cnt_sum = {1'b0, discard_cnt};
    if (io.flush) begin
      if (state == MS_WAIT && !ok_hit)                    cnt_sum = cnt_sum + CNT_ONE;
      if (io.es_to_ms_valid && io.es_to_ms_bus.es_req)    cnt_sum = cnt_sum + CNT_ONE;
    end
    if (io.data_sram_data_ok && discard_cnt != '0) cnt_sum = cnt_sum - CNT_ONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) discard_cnt <= '0;
    else         discard_cnt <= cnt_sum[CNT_W-1:0];
  end

  assign ld_src = buf_vld ? rdata_buf : io.data_sram_rdata;

  ld_align #(
    .DATA_W (DATA_W)
  ) u_ld_align (
    .rdata      (ld_src),
    .off        (ms_bus.alu_result[LANE_BITS-1:0]),
    .mem_op     (ms_bus.mem_op),
    .rt_value   (ms_bus.rt_value),
    .mem_result (mem_result)
  );

  assign final_result = ms_bus.res_from_mem ? mem_result : ms_bus.alu_result;

  always_comb begin
    io.ms_to_ws_bus    = '0;
    io.ms_to_ds_fw_bus = '0;
    if (ms_valid) begin
      io.ms_to_ws_bus.excp_valid   = ms_bus.excp_valid;
      io.ms_to_ws_bus.execode      = ms_bus.execode;
      io.ms_to_ws_bus.gr_we        = ms_bus.gr_we;
      io.ms_to_ws_bus.dest         = ms_bus.dest;
      io.ms_to_ws_bus.final_result = final_result;
      io.ms_to_ws_bus.pc           = ms_bus.pc;
      io.ms_to_ds_fw_bus.gr_we        = ms_bus.gr_we && !io.ms_fw_pending;
      io.ms_to_ds_fw_bus.dest         = ms_bus.dest;
      io.ms_to_ds_fw_bus.final_result = final_result;
    end
  end

  a_discard_range: assert property (@(posedge clk) disable iff (!resetn) cnt_sum <= CNT_MAX);
  a_wait_has_req:  assert property (@(posedge clk) disable iff (!resetn) (state == MS_WAIT) |-> ms_bus.es_req);
  a_excp_no_req:   assert property (@(posedge clk) disable iff (!resetn)
                     (accept && io.es_to_ms_bus.excp_valid) |-> !io.es_to_ms_bus.es_req);

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_async.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_async : directed steps with a result scoreboard for mem_stage_async
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage_async;
  import mem_stage_async_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_stage_async_if #(.DATA_W(32)) sif ();

  mem_stage_async #(
    .DATA_W    (32),
    .MAX_OUTST (2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (sif.slave)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called mid-cycle: score any delivery to WB, then move to the next cycle
  task automatic adv();
    logic [31:0] want;
    if (sif.ms_to_ws_valid && sif.ws_allowin) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed delivery of %0h expected none", sif.ms_to_ws_bus.final_result);
      end
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        chk("sb_result", sif.ms_to_ws_bus.final_result, want);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic es_to_ms_t mk(input int op, input logic [31:0] addr, input logic [31:0] rt,
                                   input logic req, input logic from_mem);
    es_to_ms_t e;
    e = '0;
    if (op >= 0) e.mem_op[op] = 1'b1;
    e.es_req       = req;
    e.res_from_mem = from_mem;
    e.gr_we        = 1'b1;
    e.dest         = 5'd5;
    e.rt_value     = rt;
    e.alu_result   = addr;
    e.pc           = 32'hBFC0_0100;
    return e;
  endfunction

  task automatic idle();
    sif.es_to_ms_valid    = 1'b0;
    sif.data_sram_data_ok = 1'b0;
    sif.flush             = 1'b0;
  endtask

  initial begin
    es_to_ms_t e;
    resetn = 1'b0;
    sif.es_to_ms_bus    = '0;
    sif.ws_allowin      = 1'b1;
    sif.data_sram_rdata = '0;
    idle();
    #12;
    chk("rst_allowin", sif.ms_allowin, 1'b1);
    chk("rst_valid",   sif.ms_to_ws_valid, 1'b0);
    chk("rst_ws_bus",  sif.ms_to_ws_bus, '0);
    chk("rst_fw_bus",  sif.ms_to_ds_fw_bus, '0);
    chk("rst_pending", sif.ms_fw_pending, 1'b0);
    chk("rst_state",   dut.state, MS_IDLE);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // lw with its response in the first waiting cycle: straight through to WB
    sif.es_to_ms_valid = 1'b1;
    sif.es_to_ms_bus   = mk(OP_W, 32'h1000, 32'h0, 1'b1, 1'b1);
    exp_q.push_back(32'h8899_AABB);
    #3; chk("t1_allowin", sif.ms_allowin, 1'b1); adv();
    idle(); sif.data_sram_data_ok = 1'b1; sif.data_sram_rdata = 32'h8899_AABB;
    #3; chk("t1_valid", sif.ms_to_ws_valid, 1'b1); chk("t1_dest", sif.ms_to_ws_bus.dest, 5'd5); adv();
    idle();
    #3; chk("t1_idle_valid", sif.ms_to_ws_valid, 1'b0); chk("t1_idle_state", dut.state, MS_IDLE); adv();

    // lb off 3, data three cycles late
    sif.es_to_ms_valid = 1'b1;
    sif.es_to_ms_bus   = mk(OP_B, 32'h2003, 32'h0, 1'b1, 1'b1);
    exp_q.push_back(32'hFFFF_FF80);
    #3; adv();
    idle();
    for (int i = 0; i < 3; i++) begin
      #3; chk("t2_pending", sif.ms_fw_pending, 1'b1); chk("t2_fw_we_masked", sif.ms_to_ds_fw_bus.gr_we, 1'b0); adv();
    end
    sif.data_sram_data_ok = 1'b1; sif.data_sram_rdata = 32'h8012_3456;
    #3;
    chk("t2_pending_clr", sif.ms_fw_pending, 1'b0);
    chk("t2_fw_result", sif.ms_to_ds_fw_bus.final_result, 32'hFFFF_FF80);
    chk("t2_fw_we", sif.ms_to_ds_fw_bus.gr_we, 1'b1);
    adv();
    idle();

    // lhu off 2, WB stalled for four cycles starting with the response
    sif.es_to_ms_valid = 1'b1;
    sif.es_to_ms_bus   = mk(OP_HU, 32'h3002, 32'h0, 1'b1, 1'b1);
    exp_q.push_back(32'h0000_ABCD);
    #3; adv();
    idle(); sif.ws_allowin = 1'b0; sif.data_sram_data_ok = 1'b1; sif.data_sram_rdata = 32'hABCD_1234;
    #3; chk("t3_hold_valid", sif.ms_to_ws_valid, 1'b1); adv();
    sif.data_sram_data_ok = 1'b0; sif.data_sram_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #3; chk("t3_buf_result", sif.ms_to_ws_bus.final_result, 32'h0000_ABCD); chk("t3_allowin", sif.ms_allowin, 1'b0); adv();
    end
    sif.ws_allowin = 1'b1;
    #3; chk("t3_release", sif.ms_to_ws_valid, 1'b1); adv();
    #3; chk("t3_once", sif.ms_to_ws_valid, 1'b0); adv();

    // flush in WAIT while EXE issues; two stale beats dropped, third belongs to the new lw
    sif.es_to_ms_valid = 1'b1;
    sif.es_to_ms_bus   = mk(OP_W, 32'h4000, 32'h0, 1'b1, 1'b1);
    #3; adv();
    sif.flush        = 1'b1;
    sif.es_to_ms_bus = mk(OP_W, 32'h4100, 32'h0, 1'b1, 1'b1);
    #3; adv();
    sif.flush = 1'b0;
    sif.es_to_ms_bus = mk(OP_W, 32'h5000, 32'h0, 1'b1, 1'b1);
    sif.data_sram_data_ok = 1'b1; sif.data_sram_rdata = 32'h1111_1111;
    exp_q.push_back(32'h3333_3333);
    #3; chk("t4_cnt2", dut.discard_cnt, 2'd2); chk("t4_allowin", sif.ms_allowin, 1'b1); adv();
    idle(); sif.data_sram_data_ok = 1'b1; sif.data_sram_rdata = 32'h2222_2222;
    #3;
    chk("t4_cnt1", dut.discard_cnt, 2'd1);
    chk("t4_drop_valid", sif.ms_to_ws_valid, 1'b0);
    chk("t4_drop_pending", sif.ms_fw_pending, 1'b1);
    adv();
    sif.data_sram_rdata = 32'h3333_3333;
    #3; chk("t4_cnt0", dut.discard_cnt, 2'd0); chk("t4_valid", sif.ms_to_ws_valid, 1'b1); adv();
    idle();

    // lwl off 1 then lwr off 2, the second accepted in the cycle the first leaves
    sif.es_to_ms_valid = 1'b1;
    sif.es_to_ms_bus   = mk(OP_WL, 32'h6001, 32'h1122_3344, 1'b1, 1'b1);
    exp_q.push_back(32'hCCDD_3344);
    #3; adv();
    sif.es_to_ms_bus = mk(OP_WR, 32'h6002, 32'h1122_3344, 1'b1, 1'b1);
    sif.data_sram_data_ok = 1'b1; sif.data_sram_rdata = 32'hAABB_CCDD;
    exp_q.push_back(32'h1122_AABB);
    #3; chk("t5_allowin", sif.ms_allowin, 1'b1); adv();
    sif.es_to_ms_valid = 1'b0;
    #3; chk("t5_valid", sif.ms_to_ws_valid, 1'b1); adv();
    idle();

    // store completes on its response with the address as result
    sif.es_to_ms_valid = 1'b1;
    sif.es_to_ms_bus   = mk(OP_W, 32'h7004, 32'h0, 1'b1, 1'b0);
    exp_q.push_back(32'h0000_7004);
    #3; adv();
    idle(); sif.data_sram_data_ok = 1'b1; sif.data_sram_rdata = 32'hFFFF_FFFF;
    #3; chk("st_valid", sif.ms_to_ws_valid, 1'b1); adv();
    idle();

    // excepting non-memory instruction goes straight to DONE with its cause intact
    e = mk(-1, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    e.excp_valid = 1'b1;
    e.execode    = 5'h0C;
    sif.es_to_ms_valid = 1'b1;
    sif.es_to_ms_bus   = e;
    exp_q.push_back(32'h1234_5678);
    #3; adv();
    idle();
    #3;
    chk("ex_valid", sif.ms_to_ws_valid, 1'b1);
    chk("ex_flag",  sif.ms_to_ws_bus.excp_valid, 1'b1);
    chk("ex_code",  sif.ms_to_ws_bus.execode, 5'h0C);
    chk("ex_pc",    sif.ms_to_ws_bus.pc, 32'hBFC0_0100);
    adv();

    // asynchronous reset while waiting with one stale request outstanding
    sif.es_to_ms_valid = 1'b1;
    sif.es_to_ms_bus   = mk(OP_W, 32'h8000, 32'h0, 1'b1, 1'b1);
    #3; adv();
    idle(); sif.flush = 1'b1;
    #3; adv();
    sif.flush = 1'b0;
    sif.es_to_ms_valid = 1'b1;
    sif.es_to_ms_bus   = mk(OP_W, 32'h8100, 32'h0, 1'b1, 1'b1);
    #3; adv();
    idle();
    #3;
    chk("t6_pre_state", dut.state, MS_WAIT);
    chk("t6_pre_cnt", dut.discard_cnt, 2'd1);
    resetn = 1'b0;
    #1;
    chk("t6_rst_state",   dut.state, MS_IDLE);
    chk("t6_rst_cnt",     dut.discard_cnt, 2'd0);
    chk("t6_rst_valid",   sif.ms_to_ws_valid, 1'b0);
    chk("t6_rst_allowin", sif.ms_allowin, 1'b1);
    chk("t6_rst_pending", sif.ms_fw_pending, 1'b0);
    chk("t6_rst_ws_bus",  sif.ms_to_ws_bus, '0);
    chk("t6_rst_fw_bus",  sif.ms_to_ds_fw_bus, '0);
    @(posedge clk); #1;
    resetn = 1'b1;

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
